// File: rtl/single_port_blockram_arbiter_if.sv
// rtl/single_port_blockram_arbiter_if.sv - One requester channel into single_port_blockram_arbiter
//
// Purpose: bundles one requester's request handshake and its read-response
// handshake. The requester uses the master modport and the arbiter uses the slave modport.
// Signals:
//   valid, ready             request handshake (accepted when both high)
//   write_en                 byte mask, all-zero means read
//   set_addr, write_entry    request address and write data
//   resp_valid, resp_ready   read-response handshake
//   read_entry               read data, stable while resp_valid && !resp_ready
interface single_port_blockram_arbiter_if #(
  parameter int ENTRY_W = 64,
  parameter int ADDR_W  = 6,
  parameter int MASK_W  = ENTRY_W / 8
);
  logic               valid;
  logic               ready;
  logic [MASK_W-1:0]  write_en;
  logic [ADDR_W-1:0]  set_addr;
  logic [ENTRY_W-1:0] write_entry;
  logic               resp_valid;
  logic               resp_ready;
  logic [ENTRY_W-1:0] read_entry;

  modport master (
    output valid, write_en, set_addr, write_entry, resp_ready,
    input  ready, resp_valid, read_entry
  );

  modport slave (
    input  valid, write_en, set_addr, write_entry, resp_ready,
    output ready, resp_valid, read_entry
  );
endinterface

// File: rtl/single_port_blockram_arbiter.sv
// rtl/single_port_blockram_arbiter.sv - Zero-fill and round-robin front end for one single_port_blockram
//
// Purpose: after reset, sweeps every set of the RAM with zeros. It then shares
// the single RAM port between two requesters with round-robin arbitration.
// Read data returns through a one-entry response buffer per requester.
// Ports:
//   clk_in, reset_in          clock, synchronous active-high reset
//   init_done_out             high once the zero-fill sweep has finished
//   req0, req1                requester channels (slave side of the interface)
//   ram_access_en_out         RAM access strobe
//   ram_write_en_out          RAM byte write mask (all-zero means read)
//   ram_access_set_addr_out   RAM set address
//   ram_write_entry_out       RAM write data
//   ram_read_entry_in         RAM registered read data
module single_port_blockram_arbiter #(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUM_SET                   = 64,
  parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / 8
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  output logic                                 init_done_out,
  single_port_blockram_arbiter_if.slave        req0,
  single_port_blockram_arbiter_if.slave        req1,
  output logic                                 ram_access_en_out,
  output logic [WRITE_MASK_LEN-1:0]            ram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]     ram_access_set_addr_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_write_entry_out,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_read_entry_in
);

  typedef enum logic {ST_INIT, ST_SERVE} state_e;

  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);
  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] ONE_SET  = SET_PTR_WIDTH_IN_BITS'(1);

  state_e                               state_q, state_d;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]     init_cnt_q, init_cnt_d;
  logic                                 rr_ptr_q, rr_ptr_d;
  logic                                 inflight_valid_q, inflight_valid_d;
  logic                                 inflight_id_q, inflight_id_d;
  logic [1:0]                           resp_valid_q, resp_valid_d;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] resp0_data_q, resp0_data_d;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] resp1_data_q, resp1_data_d;

  logic is_read0, is_read1, cand0, cand1, grant0, grant1;

  always_comb begin
    state_d          = state_q;
    init_cnt_d       = init_cnt_q;
    rr_ptr_d         = rr_ptr_q;
    inflight_valid_d = 1'b0;
    inflight_id_d    = inflight_id_q;
    resp_valid_d     = resp_valid_q;
    resp0_data_d     = resp0_data_q;
    resp1_data_d     = resp1_data_q;
    grant0           = 1'b0;
    grant1           = 1'b0;

    ram_access_en_out       = 1'b0;
    ram_write_en_out        = '0;
    ram_access_set_addr_out = '0;
    ram_write_entry_out     = '0;

    // A read is only eligible when its response slot is free: nothing held and
    // nothing on its way back from the RAM. Writes never need a slot.
    is_read0 = (req0.write_en == '0);
    is_read1 = (req1.write_en == '0);
    cand0 = req0.valid && (!is_read0 || (!resp_valid_q[0] && !(inflight_valid_q && !inflight_id_q)));
    cand1 = req1.valid && (!is_read1 || (!resp_valid_q[1] && !(inflight_valid_q &&  inflight_id_q)));

    case (state_q)
      ST_INIT: begin
        // Keep the RAM quiet while reset is held; the sweep starts on release.
        if (!reset_in) begin
          ram_access_en_out       = 1'b1;
          ram_write_en_out        = '1;
          ram_access_set_addr_out = init_cnt_q;
        end
        init_cnt_d = init_cnt_q + ONE_SET;
        if (init_cnt_q == LAST_SET) begin
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        // rr_ptr_q names the requester that wins a tie.
        grant0 = !reset_in && cand0 && (!cand1 || !rr_ptr_q);
        grant1 = !reset_in && cand1 && (!cand0 ||  rr_ptr_q);
        if (grant0) begin
          ram_access_en_out       = 1'b1;
          ram_write_en_out        = req0.write_en;
          ram_access_set_addr_out = req0.set_addr;
          ram_write_entry_out     = req0.write_entry;
          rr_ptr_d                = 1'b1;
          inflight_valid_d        = is_read0;
          inflight_id_d           = 1'b0;
        end else if (grant1) begin
          ram_access_en_out       = 1'b1;
          ram_write_en_out        = req1.write_en;
          ram_access_set_addr_out = req1.set_addr;
          ram_write_entry_out     = req1.write_entry;
          rr_ptr_d                = 1'b0;
          inflight_valid_d        = is_read1;
          inflight_id_d           = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Drain first, then capture. Eligibility keeps these two on different requesters.
    if (resp_valid_q[0] && req0.resp_ready) resp_valid_d[0] = 1'b0;
    if (resp_valid_q[1] && req1.resp_ready) resp_valid_d[1] = 1'b0;
    if (inflight_valid_q) begin
      if (inflight_id_q) begin
        resp1_data_d    = ram_read_entry_in;
        resp_valid_d[1] = 1'b1;
      end else begin
        resp0_data_d    = ram_read_entry_in;
        resp_valid_d[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q          <= ST_INIT;
      init_cnt_q       <= '0;
      rr_ptr_q         <= 1'b0;
      inflight_valid_q <= 1'b0;
      inflight_id_q    <= 1'b0;
      resp_valid_q     <= '0;
      resp0_data_q     <= '0;
      resp1_data_q     <= '0;
    end else begin
      state_q          <= state_d;
      init_cnt_q       <= init_cnt_d;
      rr_ptr_q         <= rr_ptr_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_id_q    <= inflight_id_d;
      resp_valid_q     <= resp_valid_d;
      resp0_data_q     <= resp0_data_d;
      resp1_data_q     <= resp1_data_d;
    end
  end

  assign init_done_out   = (state_q == ST_SERVE) && !reset_in;
  assign req0.ready      = grant0;
  assign req1.ready      = grant1;
  assign req0.resp_valid = resp_valid_q[0];
  assign req1.resp_valid = resp_valid_q[1];
  assign req0.read_entry = resp0_data_q;
  assign req1.read_entry = resp1_data_q;

endmodule

// File: tb/tb_single_port_blockram_arbiter.sv
// tb/tb_single_port_blockram_arbiter.sv - Self-checking bench for single_port_blockram_arbiter
module tb_single_port_blockram_arbiter;
  localparam int W  = 64;
  localparam int NS = 64;
  localparam int A  = 6;
  localparam int M  = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         init_done;
  logic         ram_en;
  logic [M-1:0] ram_we;
  logic [A-1:0] ram_addr;
  logic [W-1:0] ram_wdata;
  logic [W-1:0] ram_rdata;

  int checks   = 0;
  int failures = 0;
  int rr_next  = 0;

  logic [W-1:0] ram_mem [NS];
  logic [W-1:0] exp_mem [NS];

  always #5 clk = ~clk;

  single_port_blockram_arbiter_if #(.ENTRY_W(W), .ADDR_W(A), .MASK_W(M)) r0 ();
  single_port_blockram_arbiter_if #(.ENTRY_W(W), .ADDR_W(A), .MASK_W(M)) r1 ();

  single_port_blockram_arbiter #(
    .SINGLE_ENTRY_SIZE_IN_BITS(W), .NUM_SET(NS), .SET_PTR_WIDTH_IN_BITS(A), .WRITE_MASK_LEN(M)
  ) dut (
    .clk_in(clk), .reset_in(rst), .init_done_out(init_done),
    .req0(r0), .req1(r1),
    .ram_access_en_out(ram_en), .ram_write_en_out(ram_we),
    .ram_access_set_addr_out(ram_addr), .ram_write_entry_out(ram_wdata),
    .ram_read_entry_in(ram_rdata)
  );

  // Single-port RAM with registered read data and byte-masked writes.
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < M; b++)
        if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      if (ram_we == '0) ram_rdata <= ram_mem[ram_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] apply_mask(input logic [W-1:0] old, input logic [M-1:0] m,
                                              input logic [W-1:0] d);
    logic [W-1:0] r;
    r = old;
    for (int b = 0; b < M; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic set_req(input int n, input logic v, input logic [M-1:0] m, input logic [A-1:0] a,
                         input logic [W-1:0] d);
    if (n == 0) begin r0.valid = v; r0.write_en = m; r0.set_addr = a; r0.write_entry = d; end
    else        begin r1.valid = v; r1.write_en = m; r1.set_addr = a; r1.write_entry = d; end
  endtask

  task automatic set_rready(input int n, input logic v);
    if (n == 0) r0.resp_ready = v; else r1.resp_ready = v;
  endtask

  function automatic logic get_ready(input int n);
    return (n == 0) ? r0.ready : r1.ready;
  endfunction
  function automatic logic get_rvalid(input int n);
    return (n == 0) ? r0.resp_valid : r1.resp_valid;
  endfunction
  function automatic logic [W-1:0] get_rdata(input int n);
    return (n == 0) ? r0.read_entry : r1.read_entry;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NS; i++) exp_mem[i] = '0;
    rr_next = 0;
  endtask

  // Present one request until accepted; drops valid just after the accept edge.
  task automatic access(input int n, input logic [M-1:0] m, input logic [A-1:0] a,
                        input logic [W-1:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    set_req(n, 1'b1, m, a, d);
    for (int t = 0; t < 20; t++) begin
      #1;
      if (get_ready(n)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    set_req(n, 1'b0, '0, '0, '0);
    if (ok) begin
      rr_next = 1 - n;
      if (m != '0) exp_mem[a] = apply_mask(exp_mem[a], m, d);
    end
  endtask

  // lat counts negedges after the accept edge until resp_valid is seen.
  task automatic do_read(input int n, input logic [A-1:0] a, output logic [W-1:0] data,
                         output int lat, output bit ok);
    bit acc;
    access(n, '0, a, '0, acc);
    lat = 0; ok = 1'b0; data = '0;
    if (!acc) return;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk); #1;
      if (get_rvalid(n)) begin lat = t; data = get_rdata(n); ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b1, '0, 6'd1, '0);
    set_req(1, 1'b1, '0, 6'd2, '0);
    @(negedge clk); #1;
    checks++;
    if (init_done !== 1'b0 || r0.ready !== 1'b0 || r1.ready !== 1'b0 || ram_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs init_done=%0b ready=%0b%0b ram_en=%0b required 0", init_done, r0.ready, r1.ready, ram_en);
    end
    checks++;
    if (r0.resp_valid !== 1'b0 || r1.resp_valid !== 1'b0 || r0.read_entry !== '0 || r1.read_entry !== '0) begin
      failures++;
      $display("FAIL reset_resp valid=%0b%0b data0=%h data1=%h required zero", r0.resp_valid, r1.resp_valid, r0.read_entry, r1.read_entry);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NS; i++) begin
      #1;
      checks++;
      if (ram_en !== 1'b1 || ram_addr !== A'(i) || ram_we !== '1 || ram_wdata !== '0 ||
          r0.ready !== 1'b0 || r1.ready !== 1'b0 || init_done !== 1'b0) begin
        failures++;
        $display("FAIL init_sweep cycle=%0d en=%0b addr=%0d we=%h data=%h ready=%0b%0b done=%0b required en=1 addr=%0d we=ff data=0 ready=00 done=0",
                 i, ram_en, ram_addr, ram_we, ram_wdata, r0.ready, r1.ready, init_done, i);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (init_done !== 1'b1) begin
      failures++;
      $display("FAIL init_done_rise got=%0b required=1", init_done);
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    clear_model();
  endtask

  task automatic test_round_robin();
    int   exp_g;
    logic g0, g1;
    logic [A-1:0] a0, a1;
    logic [W-1:0] d0, d1;
    exp_g = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a0 = A'($urandom_range(0, 59)); a1 = A'($urandom_range(0, 59));
      d0 = {$urandom, $urandom};      d1 = {$urandom, $urandom};
      set_req(0, 1'b1, '1, a0, d0);
      set_req(1, 1'b1, '1, a1, d1);
      #1;
      g0 = r0.ready; g1 = r1.ready;
      checks++;
      if ({g0, g1} !== ((exp_g == 0) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL round_robin step=%0d ready0/1=%0b%0b required grant to %0d", i, g0, g1, exp_g);
      end
      @(posedge clk);
      if (g0 === 1'b1) begin exp_mem[a0] = d0; rr_next = 1; end
      else if (g1 === 1'b1) begin exp_mem[a1] = d1; rr_next = 0; end
      exp_g = 1 - exp_g;
    end
    #1;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
  endtask

  task automatic test_write_read();
    logic [W-1:0] d;
    int lat;
    bit ok;
    do_read(0, 6'd63, d, lat, ok);
    checks++;
    if (!ok || d !== exp_mem[63] || d !== '0 || lat != 2) begin
      failures++;
      $display("FAIL read_zeroed_63 ok=%0b data=%h lat=%0d required data=0 lat=2", ok, d, lat);
    end
    access(0, '1, 6'd63, 64'hFFFFFFFF00000000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL write63_accept got=0 required=1"); end
    do_read(0, 6'd63, d, lat, ok);
    checks++;
    if (!ok || d !== exp_mem[63] || d !== 64'hFFFFFFFF00000000 || lat != 2) begin
      failures++;
      $display("FAIL write_read_63 ok=%0b data=%h lat=%0d required data=%h lat=2", ok, d, lat, exp_mem[63]);
    end
  endtask

  task automatic test_byte_mask();
    logic [W-1:0] d;
    int lat;
    bit ok0, ok1, ok;
    access(0, '1, 6'd62, '0, ok0);
    access(0, 8'hCC, 6'd62, '1, ok1);
    do_read(0, 6'd62, d, lat, ok);
    checks++;
    if (!ok0 || !ok1 || !ok || d !== exp_mem[62] || d !== 64'hFFFF0000FFFF0000) begin
      failures++;
      $display("FAIL byte_mask ok=%0b%0b%0b data=%h required=%h", ok0, ok1, ok, d, exp_mem[62]);
    end
  endtask

  task automatic test_backpressure();
    logic [A-1:0] a, b, a0;
    logic [W-1:0] d, held, d0;
    logic g0, g1;
    int lat;
    bit ok;
    a = A'($urandom_range(0, 30));
    b = A'($urandom_range(31, 61));
    set_rready(1, 1'b0);
    access(1, '1, a, {$urandom, $urandom}, ok);
    do_read(1, a, held, lat, ok);
    checks++;
    if (!ok || held !== exp_mem[a] || lat != 2) begin
      failures++;
      $display("FAIL bp_first_read ok=%0b data=%h lat=%0d required data=%h lat=2", ok, held, lat, exp_mem[a]);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a0 = A'($urandom_range(0, 61)); d0 = {$urandom, $urandom};
      set_req(1, 1'b1, '0, b, '0);
      set_req(0, 1'b1, '1, a0, d0);
      #1;
      g0 = r0.ready; g1 = r1.ready;
      checks++;
      if (g1 !== 1'b0 || g0 !== 1'b1 || r1.resp_valid !== 1'b1 || r1.read_entry !== held) begin
        failures++;
        $display("FAIL bp_hold step=%0d ready0/1=%0b%0b rvalid1=%0b data1=%h required ready=10 rvalid=1 data=%h",
                 i, g0, g1, r1.resp_valid, r1.read_entry, held);
      end
      @(posedge clk);
      if (g0 === 1'b1) begin exp_mem[a0] = d0; rr_next = 1; end
    end
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    set_rready(1, 1'b1);
    @(negedge clk); #1;
    checks++;
    if (r1.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain rvalid1=%0b required=0", r1.resp_valid);
    end
    do_read(1, b, d, lat, ok);
    checks++;
    if (!ok || d !== exp_mem[b]) begin
      failures++;
      $display("FAIL bp_after_drain ok=%0b data=%h required=%h", ok, d, exp_mem[b]);
    end
  endtask

  task automatic test_random();
    bit           pend_v [2];
    logic [M-1:0] pend_m [2];
    logic [A-1:0] pend_a [2];
    logic [W-1:0] pend_d [2];
    bit           busy   [2];
    int           acc_c  [2];
    logic [W-1:0] exp_rd [2];
    bit           rrdy   [2];
    bit           dr     [2];
    bit           cand   [2];
    bit           ev;
    int           eg;
    for (int n = 0; n < 2; n++) begin pend_v[n] = 0; busy[n] = 0; acc_c[n] = 0; end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (!pend_v[n] && $urandom_range(0, 2) != 0) begin
          pend_v[n] = 1'b1;
          pend_m[n] = ($urandom_range(0, 1) == 1) ? M'(0) : M'($urandom);
          pend_a[n] = A'($urandom_range(0, 7));
          pend_d[n] = {$urandom, $urandom};
        end
        set_req(n, pend_v[n], pend_m[n], pend_a[n], pend_d[n]);
        rrdy[n] = ($urandom_range(0, 3) != 0);
        set_rready(n, rrdy[n]);
      end
      #1;
      for (int n = 0; n < 2; n++) cand[n] = pend_v[n] && (pend_m[n] != '0 || !busy[n]);
      if (cand[0] && cand[1]) eg = rr_next;
      else if (cand[0])       eg = 0;
      else if (cand[1])       eg = 1;
      else                    eg = -1;
      checks++;
      if (r0.ready !== (eg == 0) || r1.ready !== (eg == 1)) begin
        failures++;
        $display("FAIL rand_grant cyc=%0d ready0/1=%0b%0b required grant=%0d", c, r0.ready, r1.ready, eg);
      end
      for (int n = 0; n < 2; n++) begin
        ev = busy[n] && (c >= acc_c[n] + 2);
        checks++;
        if (get_rvalid(n) !== ev) begin
          failures++;
          $display("FAIL rand_rvalid cyc=%0d req=%0d got=%0b required=%0b", c, n, get_rvalid(n), ev);
        end
        if (ev) begin
          checks++;
          if (get_rdata(n) !== exp_rd[n]) begin
            failures++;
            $display("FAIL rand_rdata cyc=%0d req=%0d got=%h required=%h", c, n, get_rdata(n), exp_rd[n]);
          end
        end
        dr[n] = ev && rrdy[n];
      end
      @(posedge clk);
      for (int n = 0; n < 2; n++) if (dr[n]) busy[n] = 1'b0;
      if (eg >= 0) begin
        if (pend_m[eg] != '0) begin
          exp_mem[pend_a[eg]] = apply_mask(exp_mem[pend_a[eg]], pend_m[eg], pend_d[eg]);
        end else begin
          busy[eg]   = 1'b1;
          acc_c[eg]  = c;
          exp_rd[eg] = exp_mem[pend_a[eg]];
        end
        pend_v[eg] = 1'b0;
        rr_next    = 1 - eg;
      end
    end
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    set_rready(0, 1'b1);
    set_rready(1, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (r0.resp_valid !== 1'b0 || r1.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rand_quiesce rvalid=%0b%0b required=00", r0.resp_valid, r1.resp_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d;
    int lat, cnt;
    bit ok, seen;
    access(0, '1, 6'd63, 64'hA5A5_5A5A_0123_4567, ok);
    access(0, '0, 6'd63, '0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL mid_read_accept got=0 required=1"); end
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (r0.resp_valid !== 1'b0 || init_done !== 1'b0 || ram_en !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL mid_reset_outputs rvalid0=%0b done=%0b ram_en=%0b required 0", r0.resp_valid, init_done, ram_en);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (init_done === 1'b1) break;
      if (ram_en !== 1'b1 || ram_addr !== A'(cnt) || r0.resp_valid !== 1'b0) seen = 1'b1;
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != NS || seen) begin
      failures++;
      $display("FAIL mid_reinit cycles=%0d bad_drive=%0b required cycles=%0d bad_drive=0", cnt, seen, NS);
    end
    do_read(0, 6'd63, d, lat, ok);
    checks++;
    if (!ok || d !== exp_mem[63] || lat != 2) begin
      failures++;
      $display("FAIL mid_read63 ok=%0b data=%h lat=%0d required data=%h lat=2", ok, d, lat, exp_mem[63]);
    end
  endtask

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    set_rready(0, 1'b1);
    set_rready(1, 1'b1);
    repeat (3) @(posedge clk);
    test_reset();
    test_round_robin();
    test_write_read();
    test_byte_mask();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
